// File: rtl/result_drain.sv
// rtl/result_drain.sv - output-queue reader that tags results with (row, col) and frames them
//
// Purpose:
//   Drains one P x M frame of dot-product results from a show-ahead queue
//   and presents each word downstream on a valid/ready interface. Each word
//   carries its row/col position plus end-of-row and end-of-frame flags.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             begin draining one frame (sampled only in IDLE)
//   i_q_head, i_q_empty show-ahead queue head word and empty flag
//   o_q_pop             combinational pop strobe, one per word consumed
//   o_out_data/row/col  result word and its matrix position
//   o_out_last_col      word is at col M-1
//   o_out_last          word is the final word of the frame
//   o_out_valid         output word valid, i_out_ready accepts it
//   o_busy              frame in progress
//   o_frame_done        one-cycle pulse after the final word is accepted

module result_drain #(
   parameter int P          = 9,
   parameter int M          = 10,
   parameter int DATA_WIDTH = 32,
   parameter int ROW_W      = (P > 1) ? $clog2(P) : 1,
   parameter int COL_W      = (M > 1) ? $clog2(M) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_q_head,
   input  logic                  i_q_empty,
   output logic                  o_q_pop,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic [ROW_W-1:0]      o_out_row,
   output logic [COL_W-1:0]      o_out_col,
   output logic                  o_out_last_col,
   output logic                  o_out_last,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic                  o_busy,
   output logic                  o_frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST} state_t;

   localparam logic [ROW_W-1:0] LP_ROW_MAX = ROW_W'(P - 1);
   localparam logic [COL_W-1:0] LP_COL_MAX = COL_W'(M - 1);

   state_t                  r_state;
   logic [ROW_W-1:0]        r_row;
   logic [COL_W-1:0]        r_col;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [ROW_W-1:0]        r_out_row;
   logic [COL_W-1:0]        r_out_col;
   logic                    r_last_col;
   logic                    r_last;
   logic                    r_valid;
   logic                    r_busy;
   logic                    r_frame_done;

   logic                    w_accept;
   logic                    w_pop;
   logic                    w_col_end;
   logic                    w_frame_end;

   assign w_accept    = r_valid && i_out_ready;
   assign w_col_end   = (r_col == LP_COL_MAX);
   assign w_frame_end = w_col_end && (r_row == LP_ROW_MAX);
   // Pop only when the output register is free or being drained this cycle,
   // so a stalled word is never overwritten. Gated by reset so no word is
   // consumed while the block is held in reset.
   assign w_pop       = !i_rst && (r_state == S_RUN) && !i_q_empty
                        && (!r_valid || i_out_ready);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_row        <= '0;
         r_col        <= '0;
         r_data       <= '0;
         r_out_row    <= '0;
         r_out_col    <= '0;
         r_last_col   <= 1'b0;
         r_last       <= 1'b0;
         r_valid      <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;

         if (w_pop) begin
            r_data     <= i_q_head;
            r_out_row  <= r_row;
            r_out_col  <= r_col;
            r_last_col <= w_col_end;
            r_last     <= w_frame_end;
            r_valid    <= 1'b1;
            if (w_col_end) begin
               r_col <= '0;
               r_row <= w_frame_end ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_row   <= '0;
                  r_col   <= '0;
               end
            end
            S_RUN: begin
               if (w_pop && w_frame_end) r_state <= S_LAST;
            end
            S_LAST: begin
               // The final word stays in the output register until taken.
               if (w_accept) begin
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_q_pop        = w_pop;
   assign o_out_data     = r_data;
   assign o_out_row      = r_out_row;
   assign o_out_col      = r_out_col;
   assign o_out_last_col = r_last_col;
   assign o_out_last     = r_last;
   assign o_out_valid    = r_valid;
   assign o_busy         = r_busy;
   assign o_frame_done   = r_frame_done;

endmodule
